// File: rtl/lru_pkg.sv
// Shared types for the cache-way LRU tracker and its request scheduler.
//   ls_op_t       : operation code on the tracker ls_* interface
//   sched_state_t : scheduler FSM states
package lru_pkg;

  typedef enum logic [1:0] {
    OP_ILLEGAL    = 2'b00,
    OP_LOAD       = 2'b01,
    OP_STORE      = 2'b10,
    OP_INVALIDATE = 2'b11
  } ls_op_t;

  typedef enum logic {
    ARB   = 1'b0,
    FLUSH = 1'b1
  } sched_state_t;

endpackage

// File: rtl/lru_req_sched_rr_arbiter.sv
// Round-robin arbiter. The search for a valid request starts at rr_ptr;
// when advance is high the pointer moves to one past the granted index.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (rr_ptr -> 0)
//   req        : request vector
//   advance    : a grant was taken this cycle
//   gnt        : one-hot grant (combinational)
//   gnt_idx    : encoded index of the grant
module rr_arbiter #(
  parameter  int N = 3,
  localparam int R = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt,
  output logic [R-1:0] gnt_idx
);

  logic [R-1:0] rr_ptr;
  logic [R-1:0] idx;
  logic         found;
  int           k;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    k       = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= N) k = k - N;
      idx = R'(k);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (gnt_idx == R'(N - 1)) ? '0 : gnt_idx + R'(1);
    end
  end

endmodule

// File: rtl/lru_req_sched.sv
// Request scheduler in front of the LRU tracker. Arbitrates requesters
// round-robin, issues one registered op per cycle on ls_*, and returns the
// way used two cycles after the grant. A flush invalidates every way.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   req_valid_i/op/way  : per-requester request
//   req_ready_o         : one-hot grant (combinational)
//   rsp_*               : response pulse, requester id, way, error
//   flush_i/flush_busy_o: start flush / flush in progress
//   ls_*_o              : registered op to the tracker
//   lru_valid_i/way_i   : tracker store-victim selection (one-hot)
//
// state | meaning
// ARB   | arbitrate requesters, or start a flush when flush_i is high
// FLUSH | issue invalidate for way = flush counter, one per cycle
module lru_req_sched
  import lru_pkg::*;
#(
  parameter  int NUM_WAYS = 4,
  parameter  int NUM_REQ  = 3,
  localparam int W = $clog2(NUM_WAYS),
  localparam int R = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ-1:0][1:0]     req_op_i,
  input  logic [NUM_REQ-1:0][W-1:0]   req_way_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic                        rsp_valid_o,
  output logic [R-1:0]                rsp_id_o,
  output logic [W-1:0]                rsp_way_o,
  output logic                        rsp_err_o,
  input  logic                        flush_i,
  output logic                        flush_busy_o,
  output logic                        ls_valid_o,
  output logic [1:0]                  ls_op_o,
  output logic [W-1:0]                ls_way_o,
  input  logic                        lru_valid_i,
  input  logic [NUM_WAYS-1:0]         lru_way_i
);

  sched_state_t state, state_nxt;
  logic [W-1:0] cnt, cnt_nxt;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] gnt;
  logic [R-1:0]       gnt_idx;
  logic               arb_open;
  logic               transfer;

  logic         ls_valid_nxt;
  ls_op_t       ls_op_nxt;
  logic [W-1:0] ls_way_nxt;

  // Issue stage: the granted request travelling towards its response.
  logic         s1_valid, s1_valid_nxt;
  logic [R-1:0] s1_id, s1_id_nxt;
  ls_op_t       s1_op, s1_op_nxt;
  logic [W-1:0] s1_way, s1_way_nxt;

  logic [W-1:0] enc_way;
  logic [W-1:0] rsp_way_nxt;
  logic         rsp_err_nxt;

  // Gating on reset keeps req_ready_o low while reset is held.
  assign arb_open    = !reset && (state == ARB) && !flush_i;
  assign arb_req     = req_valid_i & {NUM_REQ{arb_open}};
  assign req_ready_o = gnt;
  assign transfer    = |gnt;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .advance (transfer),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    ls_valid_nxt = 1'b0;
    ls_op_nxt    = OP_ILLEGAL;
    ls_way_nxt   = '0;
    s1_valid_nxt = 1'b0;
    s1_id_nxt    = '0;
    s1_op_nxt    = OP_ILLEGAL;
    s1_way_nxt   = '0;
    case (state)
      ARB: begin
        if (flush_i) begin
          // way 0 goes out in the first FLUSH cycle, so it is loaded now
          state_nxt    = FLUSH;
          cnt_nxt      = '0;
          ls_valid_nxt = 1'b1;
          ls_op_nxt    = OP_INVALIDATE;
        end else if (transfer) begin
          s1_valid_nxt = 1'b1;
          s1_id_nxt    = gnt_idx;
          s1_op_nxt    = ls_op_t'(req_op_i[gnt_idx]);
          s1_way_nxt   = req_way_i[gnt_idx];
          if (s1_op_nxt != OP_ILLEGAL) begin
            ls_valid_nxt = 1'b1;
            ls_op_nxt    = s1_op_nxt;
            ls_way_nxt   = s1_way_nxt;
          end
        end
      end
      FLUSH: begin
        // cnt names the way on ls_* this cycle
        if (cnt == W'(NUM_WAYS - 1)) begin
          state_nxt = ARB;
        end else begin
          cnt_nxt      = cnt + 1'b1;
          ls_valid_nxt = 1'b1;
          ls_op_nxt    = OP_INVALIDATE;
          ls_way_nxt   = cnt + 1'b1;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  // Lowest set bit of the tracker selection wins.
  always_comb begin
    enc_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (lru_way_i[i]) enc_way = W'(i);
    end
  end

  always_comb begin
    rsp_way_nxt = '0;
    rsp_err_nxt = 1'b0;
    if (s1_valid) begin
      case (s1_op)
        OP_ILLEGAL: rsp_err_nxt = 1'b1;
        OP_STORE: begin
          if (!lru_valid_i || (lru_way_i == '0)) rsp_err_nxt = 1'b1;
          else                                   rsp_way_nxt = enc_way;
        end
        default: rsp_way_nxt = s1_way;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ARB;
      cnt         <= '0;
      ls_valid_o  <= 1'b0;
      ls_op_o     <= '0;
      ls_way_o    <= '0;
      s1_valid    <= 1'b0;
      s1_id       <= '0;
      s1_op       <= OP_ILLEGAL;
      s1_way      <= '0;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_way_o   <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ls_valid_o  <= ls_valid_nxt;
      ls_op_o     <= ls_op_nxt;
      ls_way_o    <= ls_way_nxt;
      s1_valid    <= s1_valid_nxt;
      s1_id       <= s1_id_nxt;
      s1_op       <= s1_op_nxt;
      s1_way      <= s1_way_nxt;
      rsp_valid_o <= s1_valid;
      rsp_id_o    <= s1_id;
      rsp_way_o   <= rsp_way_nxt;
      rsp_err_o   <= rsp_err_nxt;
    end
  end

  assign flush_busy_o = (state == FLUSH);

endmodule

// File: tb/tb_lru_req_sched.sv
// Directed bench for lru_req_sched (NUM_WAYS=4, NUM_REQ=3). Inputs change
// 1ns after the rising edge; outputs are checked 1ns later.
module tb_lru_req_sched;
  import lru_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [2:0]       req_valid;
  logic [2:0][1:0]  req_op;
  logic [2:0][1:0]  req_way;
  logic [2:0]       req_ready;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [1:0]       rsp_way;
  logic             rsp_err;
  logic             flush;
  logic             flush_busy;
  logic             ls_valid;
  logic [1:0]       ls_op;
  logic [1:0]       ls_way;
  logic             lru_valid;
  logic [3:0]       lru_way;

  int n_tests = 0;
  int n_fail  = 0;

  lru_req_sched #(.NUM_WAYS(4), .NUM_REQ(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid),
    .req_op_i     (req_op),
    .req_way_i    (req_way),
    .req_ready_o  (req_ready),
    .rsp_valid_o  (rsp_valid),
    .rsp_id_o     (rsp_id),
    .rsp_way_o    (rsp_way),
    .rsp_err_o    (rsp_err),
    .flush_i      (flush),
    .flush_busy_o (flush_busy),
    .ls_valid_o   (ls_valid),
    .ls_op_o      (ls_op),
    .ls_way_o     (ls_way),
    .lru_valid_i  (lru_valid),
    .lru_way_i    (lru_way)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] op, input logic [1:0] way);
    req_valid[i] = v;
    req_op[i]    = op;
    req_way[i]   = way;
  endtask

  task automatic check_rsp(input string tag, input logic [1:0] id, input logic [1:0] way, input logic err);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    check({tag, "_rsp_id"}, rsp_id, id);
    check({tag, "_rsp_way"}, rsp_way, way);
    check({tag, "_rsp_err"}, rsp_err, err);
  endtask

  task automatic check_ls(input string tag, input logic v, input logic [1:0] op, input logic [1:0] way);
    check({tag, "_ls_valid"}, ls_valid, v);
    check({tag, "_ls_op"}, ls_op, op);
    check({tag, "_ls_way"}, ls_way, way);
  endtask

  initial begin
    req_valid = 3'b111;
    req_op    = '0;
    req_way   = '0;
    flush     = 1'b0;
    lru_valid = 1'b0;
    lru_way   = '0;
    for (int i = 0; i < 3; i++) req_op[i] = OP_STORE;
    #2;
    // reset state
    check("rst_ready", req_ready, 3'b000);
    check_ls("rst", 1'b0, 2'b00, 2'b00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, 2'd0);
    check("rst_rsp_way", rsp_way, 2'd0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_busy", flush_busy, 1'b0);
    cyc();
    req_valid = '0;
    cyc();
    reset = 1'b0;

    // idle
    for (int c = 0; c < 10; c++) begin
      cyc();
      check("idle_rsp_valid", rsp_valid, 1'b0);
      check("idle_ls_valid", ls_valid, 1'b0);
      check("idle_busy", flush_busy, 1'b0);
      check("idle_ready", req_ready, 3'b000);
    end

    // three stores held together: grants 0,1,2
    cyc();
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, OP_STORE, 2'd0);
    lru_valid = 1'b1;
    #1 check("st_g0", req_ready, 3'b001);
    cyc();
    lru_way = 4'b0001;
    #1 check("st_g1", req_ready, 3'b010);
    check_ls("st_a1", 1'b1, OP_STORE, 2'd0);
    cyc();
    lru_way = 4'b0010;
    #1 check("st_g2", req_ready, 3'b100);
    check_rsp("st_r0", 2'd0, 2'd0, 1'b0);
    cyc();
    req_valid = '0;
    lru_way   = 4'b0100;
    #1 check("st_g3", req_ready, 3'b000);
    check_rsp("st_r1", 2'd1, 2'd1, 1'b0);
    check_ls("st_a3", 1'b1, OP_STORE, 2'd0);
    cyc();
    lru_way = '0;
    lru_valid = 1'b0;
    #1 check_rsp("st_r2", 2'd2, 2'd2, 1'b0);
    check_ls("st_a4", 1'b0, 2'b00, 2'b00);
    cyc();
    check("st_rsp_end", rsp_valid, 1'b0);

    // fairness: req1, then req0+req2 -> req2, then req0
    set_req(1, 1'b1, OP_LOAD, 2'd1);
    #1 check("rr_g1", req_ready, 3'b010);
    cyc();
    set_req(1, 1'b0, OP_LOAD, 2'd0);
    set_req(0, 1'b1, OP_LOAD, 2'd3);
    set_req(2, 1'b1, OP_LOAD, 2'd2);
    #1 check("rr_g2", req_ready, 3'b100);
    check_ls("rr_a1", 1'b1, OP_LOAD, 2'd1);
    cyc();
    set_req(2, 1'b0, OP_LOAD, 2'd0);
    #1 check("rr_g0", req_ready, 3'b001);
    check_ls("rr_a2", 1'b1, OP_LOAD, 2'd2);
    check_rsp("rr_r1", 2'd1, 2'd1, 1'b0);
    cyc();
    req_valid = '0;
    #1 check_rsp("rr_r2", 2'd2, 2'd2, 1'b0);
    check_ls("rr_a0", 1'b1, OP_LOAD, 2'd3);
    cyc();
    check_rsp("rr_r0", 2'd0, 2'd3, 1'b0);

    // store with multi-bit selection: lowest set bit wins
    set_req(0, 1'b1, OP_STORE, 2'd0);
    #1 check("mb_g", req_ready, 3'b001);
    cyc();
    req_valid = '0;
    lru_valid = 1'b1;
    lru_way   = 4'b1010;
    cyc();
    lru_valid = 1'b0;
    lru_way   = '0;
    #1 check_rsp("mb_r", 2'd0, 2'd1, 1'b0);

    // store with no tracker selection
    set_req(1, 1'b1, OP_STORE, 2'd2);
    #1 check("ns_g", req_ready, 3'b010);
    cyc();
    req_valid = '0;
    lru_valid = 1'b0;
    lru_way   = 4'b0100;
    cyc();
    lru_way = '0;
    #1 check_rsp("ns_r", 2'd1, 2'd0, 1'b1);

    // load 3, invalidate 3, store (victim 3) from req2 (rr_ptr now 2)
    set_req(2, 1'b1, OP_LOAD, 2'd3);
    #1 check("lis_g0", req_ready, 3'b100);
    cyc();
    set_req(2, 1'b1, OP_INVALIDATE, 2'd3);
    #1 check("lis_g1", req_ready, 3'b100);
    check_ls("lis_a0", 1'b1, 2'b01, 2'd3);
    cyc();
    set_req(2, 1'b1, OP_STORE, 2'd3);
    #1 check("lis_g2", req_ready, 3'b100);
    check_ls("lis_a1", 1'b1, 2'b11, 2'd3);
    check_rsp("lis_r0", 2'd2, 2'd3, 1'b0);
    cyc();
    req_valid = '0;
    lru_valid = 1'b1;
    lru_way   = 4'b1000;
    #1 check_ls("lis_a2", 1'b1, 2'b10, 2'd3);
    check_rsp("lis_r1", 2'd2, 2'd3, 1'b0);
    cyc();
    lru_valid = 1'b0;
    lru_way   = '0;
    #1 check_rsp("lis_r2", 2'd2, 2'd3, 1'b0);
    check_ls("lis_a3", 1'b0, 2'b00, 2'b00);

    // grant just before flush, then flush with a pending request
    cyc();
    set_req(0, 1'b1, OP_LOAD, 2'd2);
    #1 check("fl_pre_g", req_ready, 3'b001);
    cyc();
    set_req(0, 1'b0, OP_LOAD, 2'd0);
    set_req(1, 1'b1, OP_LOAD, 2'd1);
    flush = 1'b1;
    #1 check("fl_nogrant", req_ready, 3'b000);
    check("fl_busy_n", flush_busy, 1'b0);
    check_ls("fl_pre_a", 1'b1, OP_LOAD, 2'd2);
    for (int k = 0; k < 4; k++) begin
      cyc();
      flush = (k == 1);
      #1 check("fl_busy", flush_busy, 1'b1);
      check("fl_ready", req_ready, 3'b000);
      check_ls("fl_inv", 1'b1, OP_INVALIDATE, 2'(k));
      if (k == 0) check_rsp("fl_overlap", 2'd0, 2'd2, 1'b0);
      else        check("fl_norsp", rsp_valid, 1'b0);
    end
    cyc();
    flush = 1'b0;
    #1 check("fl_done_busy", flush_busy, 1'b0);
    check("fl_resume_g", req_ready, 3'b010);
    check_ls("fl_done", 1'b0, 2'b00, 2'b00);
    cyc();
    req_valid = '0;
    #1 check_ls("fl_after", 1'b1, OP_LOAD, 2'd1);
    check("fl_busy_stays_low", flush_busy, 1'b0);
    cyc();
    check_rsp("fl_r", 2'd1, 2'd1, 1'b0);

    // illegal op from req2 (rr_ptr now 2)
    set_req(2, 1'b1, OP_ILLEGAL, 2'd3);
    #1 check("il_g", req_ready, 3'b100);
    cyc();
    req_valid = '0;
    #1 check_ls("il_a", 1'b0, 2'b00, 2'b00);
    check("il_norsp", rsp_valid, 1'b0);
    cyc();
    check_rsp("il_r", 2'd2, 2'd0, 1'b1);

    // reset one cycle after a store grant (rr_ptr 0 -> 1 on this grant)
    set_req(0, 1'b1, OP_STORE, 2'd1);
    #1 check("rs_g", req_ready, 3'b001);
    cyc();
    req_valid = '0;
    reset     = 1'b1;
    lru_valid = 1'b1;
    lru_way   = 4'b0001;
    #1 check("rs_ls_clr", ls_valid, 1'b0);
    check("rs_ready", req_ready, 3'b000);
    cyc();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      check("rs_no_ls", ls_valid, 1'b0);
      check("rs_no_rsp", rsp_valid, 1'b0);
    end
    lru_valid = 1'b0;
    lru_way   = '0;
    set_req(0, 1'b1, OP_LOAD, 2'd0);
    set_req(2, 1'b1, OP_LOAD, 2'd0);
    #1 check("rs_ptr_reset", req_ready, 3'b001);
    cyc();
    req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lru_req_sched.md
# lru_req_sched

Request scheduler for the cache-way LRU tracker: arbitrates round-robin among NUM_REQ load/store/invalidate requesters, issues at most one operation per cycle on the tracker's ls_* interface, and returns the way used (the victim way for stores) to the winning requester. A flush sequencer invalidates every way in order. Sits between the cache pipeline clients and the `lru` instance, whose reset it shares.

## Interface
- NUM_WAYS, 4, ways tracked; power of two, ≥2; W = $clog2(NUM_WAYS)
- NUM_REQ, 3, requester ports, ≥2; R = $clog2(NUM_REQ)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_op_i  in  NUM_REQ×2  per-requester op: 01 load, 10 store, 11 invalidate, 00 illegal
- req_way_i  in  NUM_REQ×W  way for load/invalidate; ignored for store
- req_ready_o  out  NUM_REQ  one-hot grant; at most one bit high
- rsp_valid_o  out  1  response valid, single-cycle pulse
- rsp_id_o  out  R  requester index of the response
- rsp_way_o  out  W  encoded way used
- rsp_err_o  out  1  illegal op, or store with no tracker selection
- flush_i  in  1  start invalidating all ways
- flush_busy_o  out  1  flush in progress
- ls_valid_o / ls_op_o / ls_way_o  out  1/2/W  registered drive to the tracker
- lru_valid_i  in  1  tracker store-selection valid
- lru_way_i  in  NUM_WAYS  tracker one-hot selected way

## Operation
- FSM states: ARB, FLUSH. Reset state: ARB.
- ARB, flush_i low:
  - Round-robin grant among valid requesters. Search starts at rr_ptr.
  - req_ready_o is combinational from req_valid_i and rr_ptr. A transfer is valid&ready.
  - On a grant to index g: rr_ptr <= (g+1) mod NUM_REQ.
  - With no valid requester, rr_ptr holds.
- ARB, flush_i high:
  - No grant that cycle; all req_ready_o low.
  - FSM → FLUSH, flush counter <= 0.
  - flush_i has priority over any simultaneous request.
- FLUSH:
  - Issue invalidate for way = counter on consecutive cycles, counter incrementing by 1 per cycle.
  - After way NUM_WAYS-1 is issued: → ARB.
  - flush_busy_o high for exactly NUM_WAYS cycles. req_ready_o all low throughout.
  - flush_i while in FLUSH is ignored and is not queued.
  - FLUSH produces no responses.
- Legal op (01/10/11) granted in cycle N: ls_valid_o=1, ls_op_o=op, ls_way_o=req_way_i in cycle N+1. The load/invalidate way is forwarded unchanged.
- Illegal op 00: accepted, nothing issued (ls_valid_o=0 in N+1), response with rsp_err_o=1 and rsp_way_o=0.
- Store response:
  - Capture lru_way_i in cycle N+1 and encode it to rsp_way_o.
  - If lru_valid_i=0 or lru_way_i=0: rsp_err_o=1, rsp_way_o=0.
  - If more than one bit is set, the lowest set index wins.
- Load/invalidate response: rsp_way_o = requested way, rsp_err_o=0.
- ls_op_o/ls_way_o are 0 whenever ls_valid_o=0.

## Timing
- Reset values:
  - req_ready_o combinational; it evaluates to 0 while reset is asserted.
  - ls_valid_o, ls_op_o, ls_way_o = 0.
  - rsp_valid_o, rsp_id_o, rsp_way_o, rsp_err_o = 0.
  - flush_busy_o = 0; rr_ptr = 0; flush counter = 0.
- Grant cycle N → tracker op cycle N+1 → rsp_valid_o cycle N+2. Fixed latency 2, no backpressure on responses.
- Throughput: one grant per cycle. Back-to-back grants produce back-to-back ls ops and responses.
- Flush asserted in cycle N: invalidates issued in N+1…N+NUM_WAYS. flush_busy_o high in N+1…N+NUM_WAYS. First possible new grant is N+NUM_WAYS+1.
- A grant in cycle N-1 still completes: its response at N+1 overlaps the flush.
- Reset mid-operation: in-flight ops and responses are dropped and the FSM returns to ARB. No response is emitted after reset release for pre-reset grants.

## Structure
- Shared package lru_pkg:
  - ls_op_t enum: OP_LOAD=2'b01, OP_STORE=2'b10, OP_INVALIDATE=2'b11, OP_ILLEGAL=2'b00.
  - FSM state enum sched_state_t {ARB, FLUSH}.
- The `lru` tracker must import the same ls_op_t.
- Sub-module rr_arbiter (parameter N):
  - req[N] in; gnt[N] one-hot out; gnt_idx out; advance in.
  - Owns rr_ptr, reset to 0.
- Kept in lru_req_sched: FSM, flush counter, the issue/response pipeline registers, and the one-hot→encoded priority encoder.

## Test plan
- Reset then idle: all outputs 0, flush_busy_o=0, no rsp_valid_o for 10 cycles.
- Requesters 0, 1, 2 all hold store for 3 cycles:
  - Grants 0, 1, 2 in order.
  - Responses in the following cycles with rsp_id 0, 1, 2 and rsp_way 0, 1, 2 (empty tracker).
- Round-robin fairness:
  - Req1 granted, then req0 and req2 request together: req2 wins, req0 next.
  - After the 4 ways fill, a 5th store gets rsp_way = LRU way.
- Load way 3, then invalidate way 3, then store:
  - Store response rsp_way=3, rsp_err=0.
  - ls_op_o sequence 01, 11, 10.
- flush_i together with a valid request:
  - No grant that cycle.
  - Invalidates for ways 0,1,2,3 on 4 consecutive cycles; flush_busy_o high for 4 cycles.
  - Grant resumes the following cycle; a second flush_i mid-flush is ignored.
- Illegal op 00 from req2:
  - req_ready_o[2]=1, no ls_valid_o.
  - Response at N+2: rsp_id=2, rsp_err=1.
- Assert reset one cycle after a store grant: no ls op or response appears after reset release.
